// File: rtl/mac_accum.sv
// mac_accum: pipelined multiply-accumulate over framed term streams,
// with saturating/wrapping result and a sticky missing-first flag.
module mac_accum #(
    parameter int WIDTHA   = 8,
    parameter int WIDTHB   = 8,
    parameter int WIDTHP   = 24,
    parameter int PIPELINE = 2,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              clken,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [WIDTHA-1:0] dataa,
    input  logic [WIDTHB-1:0] datab,
    input  logic [WIDTHP-1:0] bias,
    output logic [WIDTHP-1:0] result,
    output logic              out_valid,
    output logic [15:0]       out_count,
    output logic              err_nofirst
);
    localparam int PW = WIDTHA + WIDTHB;
    localparam int AW = WIDTHP + 8;
    localparam logic S = (SIGNED != 0);
    localparam logic [WIDTHP-1:0] MAXS = {1'b0, {(WIDTHP-1){1'b1}}};
    localparam logic [WIDTHP-1:0] MINS = {1'b1, {(WIDTHP-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    logic [PW-1:0]     prod;
    logic [PW-1:0]     p_q [PIPELINE];
    logic [WIDTHP-1:0] b_q [PIPELINE];
    logic              v_q [PIPELINE];
    logic              f_q [PIPELINE];
    logic              l_q [PIPELINE];
    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d, pe, be;
    logic [15:0]       cnt_q, cnt_d, ocnt_q;
    logic              fin_q, fin_d, err_q, err_d, ov_q, ovf_s, ovf_u;
    logic [WIDTHP-1:0] res_q, res_d;

    // Operands are extended to full product width so one unsigned multiply
    // yields the correct low bits for both signed and unsigned modes.
    assign prod = {{WIDTHB{S & dataa[WIDTHA-1]}}, dataa} * {{WIDTHA{S & datab[WIDTHB-1]}}, datab};
    assign pe = {{(AW-PW){S & p_q[PIPELINE-1][PW-1]}}, p_q[PIPELINE-1]};
    assign be = {{8{S & b_q[PIPELINE-1][WIDTHP-1]}}, b_q[PIPELINE-1]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        fin_d   = 1'b0;
        err_d   = err_q;
        if (v_q[PIPELINE-1]) begin
            if (f_q[PIPELINE-1] || state_q == IDLE) begin
                acc_d = (f_q[PIPELINE-1] ? be : {AW{1'b0}}) + pe;
                cnt_d = 16'd1;
                err_d = err_q | ~f_q[PIPELINE-1];
            end else begin
                acc_d = acc_q + pe;
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
            end
            fin_d   = l_q[PIPELINE-1];
            state_d = l_q[PIPELINE-1] ? IDLE : ACCUM;
        end
    end

    always_comb begin
        ovf_s = acc_q[AW-1:WIDTHP-1] != {(AW-WIDTHP+1){acc_q[AW-1]}};
        ovf_u = |acc_q[AW-1:WIDTHP];
        res_d = (SATURATE == 0) ? acc_q[WIDTHP-1:0] :
                S ? (ovf_s ? (acc_q[AW-1] ? MINS : MAXS) : acc_q[WIDTHP-1:0]) :
                    (ovf_u ? {WIDTHP{1'b1}} : acc_q[WIDTHP-1:0]);
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            for (int i = 0; i < PIPELINE; i++) begin
                p_q[i] <= '0;
                b_q[i] <= '0;
                v_q[i] <= 1'b0;
                f_q[i] <= 1'b0;
                l_q[i] <= 1'b0;
            end
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            ocnt_q  <= '0;
            ov_q    <= 1'b0;
        end else if (clken) begin
            p_q[0] <= prod;
            b_q[0] <= bias;
            v_q[0] <= in_valid;
            f_q[0] <= in_first;
            l_q[0] <= in_last;
            for (int i = 1; i < PIPELINE; i++) begin
                p_q[i] <= p_q[i-1];
                b_q[i] <= b_q[i-1];
                v_q[i] <= v_q[i-1];
                f_q[i] <= f_q[i-1];
                l_q[i] <= l_q[i-1];
            end
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            ov_q    <= fin_q;
            if (fin_q) begin
                res_q  <= res_d;
                ocnt_q <= cnt_q;
            end
        end
    end

    assign result      = res_q;
    assign out_valid   = ov_q;
    assign out_count   = ocnt_q;
    assign err_nofirst = err_q;
endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter WIDTHA, default 8: width of operand dataa.
REQ-002 SHALL have parameter WIDTHB, default 8: width of operand datab.
REQ-003 SHALL have parameter WIDTHP, default 24: width of bias and result.
REQ-004 SHALL have parameter PIPELINE, default 2, legal 1..4: number of multiplier register stages.
REQ-005 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, bias and result; 0 = unsigned.
REQ-006 SHALL have parameter SATURATE, default 1: 1 = clamp result to WIDTHP; 0 = truncate (wrap).
REQ-007 SHALL have port clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-008 SHALL have port aclr, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port clken, input, 1 bit: global enable; 0 freezes every register.
REQ-010 SHALL have port in_valid, input, 1 bit: the dataa/datab pair is a term.
REQ-011 SHALL have port in_first, input, 1 bit: this term opens a new accumulation.
REQ-012 SHALL have port in_last, input, 1 bit: this term closes the accumulation.
REQ-013 SHALL have port dataa, input, WIDTHA bits: multiplicand.
REQ-014 SHALL have port datab, input, WIDTHB bits: multiplier.
REQ-015 SHALL have port bias, input, WIDTHP bits: accumulator seed, sampled only with in_first.
REQ-016 SHALL have port result, output, WIDTHP bits: closed accumulation value.
REQ-017 SHALL have port out_valid, output, 1 bit: result is new.
REQ-018 SHALL have port out_count, output, 16 bits: number of terms in result, saturating at 65535.
REQ-019 SHALL have port err_nofirst, output, 1 bit: sticky protocol-error flag.

Function
REQ-020 SHALL sample in_valid, in_first, in_last, dataa, datab and bias only on edges with clken=1; in_first/in_last SHALL be ignored when in_valid=0.
REQ-021 SHALL carry the full-precision product (WIDTHA+WIDTHB bits) through PIPELINE stages, with valid/first/last/bias travelling alongside.
REQ-022 SHALL sign-extend the product and bias when SIGNED=1 and zero-extend them when SIGNED=0 into an accumulator of WIDTHP+8 bits.
REQ-023 SHALL run an accumulator FSM with states IDLE (no open accumulation) and ACCUM.
REQ-024 On a term arriving with first=1, in any state: acc <- bias + product, discarding any open partial sum; count <- 1.
REQ-025 On a term arriving in ACCUM with first=0: acc <- acc + product; count <- count+1, saturating at 65535.
REQ-026 On a term arriving in IDLE with first=0: the term SHALL be treated as first=1 with bias=0, and err_nofirst SHALL be set.
REQ-027 On a term with last=1: result <- final acc, out_count <- final count, out_valid <- 1, and the FSM goes to IDLE; otherwise the FSM goes to ACCUM.
REQ-028 first=1 together with last=1 SHALL be a one-term accumulation: result = bias + product.
REQ-029 out_valid SHALL go to 0 on the next enabled edge with no closing term, and SHALL be 1 on consecutive enabled edges when back-to-back accumulations close.
REQ-030 Latency from an enabled edge sampling in_last=1 to out_valid=1 SHALL be PIPELINE+1 enabled edges.
REQ-031 Throughput SHALL be one term per enabled cycle with no bubbles.
REQ-032 With SATURATE=1, an acc exceeding the WIDTHP range SHALL clamp to the max or min code (signed) or to all-ones (unsigned); with SATURATE=0, result SHALL be the low WIDTHP bits.
REQ-033 Overflow of the WIDTHP+8 accumulator itself SHALL wrap (undefined use).
REQ-034 With clken=0, every register SHALL hold, including out_valid; the consumer qualifies out_valid with clken.

Reset
REQ-035 aclr=1 at an edge SHALL override clken and clear all pipeline valids, acc, count, result, out_count, out_valid and err_nofirst to 0, and set the FSM to IDLE.
REQ-036 A term in flight during reset SHALL be discarded.
REQ-037 err_nofirst SHALL clear only on aclr.

Verification
REQ-038 Use SIGNED=1, PIPELINE=2, bias=10, and the terms (3,4) first, (-2,5), (7,1) last -> result=19, out_count=3, and out_valid high for exactly one edge, 3 edges after the last term.
REQ-039 Use a one-term accumulation: (-8,-8) with first=1, last=1, bias=0 -> result=64, out_count=1.
REQ-040 Saturation: WIDTHP=16, SATURATE=1, and 3 terms of (127,127) plus bias=32767 -> result=32767; repeat with SATURATE=0 -> result=(32767+48387) mod 2^16, read as signed = 15618.
REQ-041 Drive clken=0 for 5 cycles mid-stream -> result and latency in enabled edges are unchanged, and out_valid holds its value across the stall.
REQ-042 Drive a term with first=0 right after reset, with last=1 and product 6 -> result=6 and err_nofirst=1 until aclr.
REQ-043 Assert aclr for one edge while 2 terms are in the pipeline -> no out_valid follows, and all outputs are 0.
